// File: rtl/pad_alsaqr_ctrl.sv
// Pad controller: applies pad configuration with direction-turnaround sequencing and debounces pad readback.
// Latency: config 1 cycle; pad_i_o 1 cycle; in_data_o 2 sync cycles + max(1,deb) debounce cycles.
// Backpressure: cfg_ready_o low for TURN_CYC cycles after a direction change; cfg_valid_i ignored meanwhile.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cfg_valid_i / cfg_ready_o     configuration handshake
//   cfg_dir_i                     1 = output mode
//   cfg_puen_i                    1 = pull-up, 0 = pull-down
//   cfg_drv_i, cfg_slw_i,
//   cfg_smt_i, cfg_deb_i          drive strength, slew, Schmitt enable, debounce threshold
//   out_data_i                    core data to drive onto the pad
//   in_data_o, in_edge_o          debounced pad input and one-cycle change pulse
//   busy_o                        high while a turnaround is in progress
//   pad_i_o, pad_oen_o,
//   pad_puen_o, pad_drv_o,
//   pad_slw_o, pad_smt_o          pad-side controls (pad_oen_o = 1 tristates the driver)
//   pad_o_i                       pad Y (asynchronous to clk_i)

module pad_alsaqr_ctrl #(
   parameter int unsigned TURN_CYC = 2,
   parameter int unsigned DEB_W    = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic             cfg_dir_i,
   input  logic             cfg_puen_i,
   input  logic [1:0]       cfg_drv_i,
   input  logic             cfg_slw_i,
   input  logic             cfg_smt_i,
   input  logic [DEB_W-1:0] cfg_deb_i,
   input  logic             out_data_i,
   output logic             in_data_o,
   output logic             in_edge_o,
   output logic             busy_o,
   output logic             pad_i_o,
   output logic             pad_oen_o,
   output logic             pad_puen_o,
   output logic [1:0]       pad_drv_o,
   output logic             pad_slw_o,
   output logic             pad_smt_o,
   input  logic             pad_o_i
);

   typedef enum logic {
      IDLE = 1'b0,
      TURN = 1'b1
   } state_t;

   localparam logic [3:0]       TURN_LOAD = 4'(TURN_CYC - 1);
   localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);

   state_t           state;
   logic             dir;        // current direction, 1 = output
   logic [3:0]       turn_cnt;
   logic [DEB_W-1:0] deb_thr;
   logic             accept;
   logic             turn_done;

   logic             sync_q1;
   logic             sync_q2;
   logic [DEB_W-1:0] deb_cnt;
   logic [DEB_W-1:0] thr_eff;
   logic             deb_hit;

   assign accept    = cfg_valid_i & cfg_ready_o;
   assign turn_done = (state == TURN) && (turn_cnt == 4'd0);

   // Control FSM with registered outputs. The driver enable only changes
   // at the ends of a turnaround: it is released immediately when leaving
   // output mode and asserted only after the full turnaround when entering it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         dir         <= 1'b0;
         turn_cnt    <= 4'd0;
         deb_thr     <= '0;
         cfg_ready_o <= 1'b1;
         busy_o      <= 1'b0;
         pad_oen_o   <= 1'b1;
         pad_puen_o  <= 1'b0;
         pad_drv_o   <= 2'b00;
         pad_slw_o   <= 1'b0;
         pad_smt_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  pad_puen_o <= cfg_puen_i;
                  pad_drv_o  <= cfg_drv_i;
                  pad_slw_o  <= cfg_slw_i;
                  pad_smt_o  <= cfg_smt_i;
                  deb_thr    <= cfg_deb_i;
                  dir        <= cfg_dir_i;
                  if (cfg_dir_i != dir) begin
                     state       <= TURN;
                     turn_cnt    <= TURN_LOAD;
                     cfg_ready_o <= 1'b0;
                     busy_o      <= 1'b1;
                     pad_oen_o   <= 1'b1;
                  end
               end
            end
            TURN: begin
               if (turn_cnt == 4'd0) begin
                  state       <= IDLE;
                  cfg_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
                  pad_oen_o   <= ~dir;
               end else begin
                  turn_cnt <= turn_cnt - 4'd1;
               end
            end
            default: begin
               state       <= IDLE;
               cfg_ready_o <= 1'b1;
               busy_o      <= 1'b0;
            end
         endcase
      end
   end

   // A threshold arriving on this edge already governs this edge's decision;
   // the running mismatch count is kept, so lowering the threshold can fire
   // immediately. A threshold of 0 behaves as 1.
   assign thr_eff = accept ? cfg_deb_i : deb_thr;
   assign deb_hit = (thr_eff == '0) || (deb_cnt >= (thr_eff - DEB_ONE));

   // Data path, input synchronizer and debouncer. The debouncer is frozen
   // during a turnaround because the pad is floating or fighting then, and
   // restarts from a clean count once the turnaround completes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pad_i_o   <= 1'b0;
         sync_q1   <= 1'b0;
         sync_q2   <= 1'b0;
         deb_cnt   <= '0;
         in_data_o <= 1'b0;
         in_edge_o <= 1'b0;
      end else begin
         pad_i_o   <= out_data_i;
         sync_q1   <= pad_o_i;
         sync_q2   <= sync_q1;
         in_edge_o <= 1'b0;
         if (state == TURN) begin
            if (turn_done) begin
               deb_cnt <= '0;
            end
         end else if (sync_q2 != in_data_o) begin
            if (deb_hit) begin
               in_data_o <= sync_q2;
               in_edge_o <= 1'b1;
               deb_cnt   <= '0;
            end else if (deb_cnt != '1) begin
               deb_cnt <= deb_cnt + DEB_ONE;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pad_alsaqr_ctrl.sv
// Testbench for pad_alsaqr_ctrl with default parameters (TURN_CYC=2, DEB_W=4).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// Pad data path is scoreboarded through a queue; other features are checked inline per task.

module tb_pad_alsaqr_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b1;
   logic       cfg_valid_i = 1'b0;
   logic       cfg_ready_o;
   logic       cfg_dir_i = 1'b0;
   logic       cfg_puen_i = 1'b0;
   logic [1:0] cfg_drv_i = 2'b00;
   logic       cfg_slw_i = 1'b0;
   logic       cfg_smt_i = 1'b0;
   logic [3:0] cfg_deb_i = 4'd0;
   logic       out_data_i = 1'b0;
   logic       in_data_o;
   logic       in_edge_o;
   logic       busy_o;
   logic       pad_i_o;
   logic       pad_oen_o;
   logic       pad_puen_o;
   logic [1:0] pad_drv_o;
   logic       pad_slw_o;
   logic       pad_smt_o;
   logic       pad_o_i = 1'b0;

   int checks = 0;
   int errors = 0;
   logic exp_q[$];

   pad_alsaqr_ctrl #(.TURN_CYC(2), .DEB_W(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_dir_i(cfg_dir_i), .cfg_puen_i(cfg_puen_i), .cfg_drv_i(cfg_drv_i),
      .cfg_slw_i(cfg_slw_i), .cfg_smt_i(cfg_smt_i), .cfg_deb_i(cfg_deb_i),
      .out_data_i(out_data_i), .in_data_o(in_data_o), .in_edge_o(in_edge_o),
      .busy_o(busy_o), .pad_i_o(pad_i_o), .pad_oen_o(pad_oen_o),
      .pad_puen_o(pad_puen_o), .pad_drv_o(pad_drv_o), .pad_slw_o(pad_slw_o),
      .pad_smt_o(pad_smt_o), .pad_o_i(pad_o_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_cfg(input logic v, input logic d, input logic pu, input logic [1:0] dr,
                          input logic sl, input logic sm, input logic [3:0] db);
      cfg_valid_i = v;
      cfg_dir_i   = d;
      cfg_puen_i  = pu;
      cfg_drv_i   = dr;
      cfg_slw_i   = sl;
      cfg_smt_i   = sm;
      cfg_deb_i   = db;
   endtask

   task automatic test_reset();
      #2 rst_ni = 1'b0;
      #1;
      checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cfg_ready_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
      checks++; if (pad_oen_o !== 1'b1) begin errors++; $display("FAIL rst_oen got %b exp 1", pad_oen_o); end
      checks++; if ({pad_puen_o, pad_drv_o, pad_slw_o, pad_smt_o, pad_i_o} !== 6'b0) begin errors++; $display("FAIL rst_padcfg got %b exp 000000", {pad_puen_o, pad_drv_o, pad_slw_o, pad_smt_o, pad_i_o}); end
      checks++; if ({in_data_o, in_edge_o} !== 2'b00) begin errors++; $display("FAIL rst_in got %b exp 00", {in_data_o, in_edge_o}); end
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      checks++; if ({cfg_ready_o, busy_o, pad_oen_o} !== 3'b101) begin errors++; $display("FAIL rst_release got %b exp 101", {cfg_ready_o, busy_o, pad_oen_o}); end
   endtask

   task automatic test_in_to_out();
      set_cfg(1, 1, 0, 2'b11, 0, 0, 4'd3);
      tick();
      cfg_valid_i = 1'b0;
      checks++; if (pad_drv_o !== 2'd3) begin errors++; $display("FAIL i2o_drv got %0d exp 3", pad_drv_o); end
      checks++; if ({pad_oen_o, busy_o, cfg_ready_o} !== 3'b110) begin errors++; $display("FAIL i2o_t0 got %b exp 110", {pad_oen_o, busy_o, cfg_ready_o}); end
      tick();
      checks++; if ({pad_oen_o, busy_o, cfg_ready_o} !== 3'b110) begin errors++; $display("FAIL i2o_t1 got %b exp 110", {pad_oen_o, busy_o, cfg_ready_o}); end
      tick();
      checks++; if ({pad_oen_o, busy_o, cfg_ready_o} !== 3'b001) begin errors++; $display("FAIL i2o_t2 got %b exp 001", {pad_oen_o, busy_o, cfg_ready_o}); end
   endtask

   // Runs in output mode, so it also covers pad readback while driving.
   task automatic test_debounce();
      pad_o_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if ({in_data_o, in_edge_o} !== 2'b00) begin errors++; $display("FAIL deb_wait%0d got %b exp 00", i, {in_data_o, in_edge_o}); end
      end
      tick();
      checks++; if ({in_data_o, in_edge_o} !== 2'b11) begin errors++; $display("FAIL deb_rise got %b exp 11", {in_data_o, in_edge_o}); end
      tick();
      checks++; if ({in_data_o, in_edge_o} !== 2'b10) begin errors++; $display("FAIL deb_pulse got %b exp 10", {in_data_o, in_edge_o}); end
      pad_o_i = 1'b0;
      tick();
      tick();
      pad_o_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if ({in_data_o, in_edge_o} !== 2'b10) begin errors++; $display("FAIL deb_glitch%0d got %b exp 10", i, {in_data_o, in_edge_o}); end
      end
   endtask

   task automatic test_same_dir();
      set_cfg(1, 1, 0, 2'b11, 0, 1, 4'd3);
      tick();
      checks++; if (pad_smt_o !== 1'b1) begin errors++; $display("FAIL same_smt got %b exp 1", pad_smt_o); end
      checks++; if ({busy_o, cfg_ready_o, pad_oen_o} !== 3'b010) begin errors++; $display("FAIL same_state got %b exp 010", {busy_o, cfg_ready_o, pad_oen_o}); end
      set_cfg(1, 1, 1, 2'b11, 1, 1, 4'd3);
      tick();
      cfg_valid_i = 1'b0;
      checks++; if ({pad_slw_o, pad_puen_o} !== 2'b11) begin errors++; $display("FAIL b2b_cfg got %b exp 11", {pad_slw_o, pad_puen_o}); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b exp 0", busy_o); end
   endtask

   task automatic test_out_to_in();
      pad_o_i = 1'b0;
      set_cfg(1, 0, 0, 2'b01, 0, 0, 4'd1);
      tick();
      cfg_valid_i = 1'b0;
      checks++; if ({pad_oen_o, busy_o, cfg_ready_o} !== 3'b110) begin errors++; $display("FAIL o2i_t0 got %b exp 110", {pad_oen_o, busy_o, cfg_ready_o}); end
      checks++; if (pad_drv_o !== 2'd1) begin errors++; $display("FAIL o2i_drv got %0d exp 1", pad_drv_o); end
      tick();
      checks++; if ({in_data_o, busy_o} !== 2'b11) begin errors++; $display("FAIL o2i_freeze1 got %b exp 11", {in_data_o, busy_o}); end
      tick();
      checks++; if ({in_data_o, busy_o, cfg_ready_o, pad_oen_o} !== 4'b1011) begin errors++; $display("FAIL o2i_idle got %b exp 1011", {in_data_o, busy_o, cfg_ready_o, pad_oen_o}); end
      tick();
      checks++; if ({in_data_o, in_edge_o} !== 2'b01) begin errors++; $display("FAIL o2i_resume got %b exp 01", {in_data_o, in_edge_o}); end
   endtask

   task automatic test_backpressure();
      set_cfg(1, 1, 0, 2'b10, 0, 0, 4'd1);
      tick();
      checks++; if ({busy_o, pad_drv_o} !== 3'b110) begin errors++; $display("FAIL bp_first got %b exp 110", {busy_o, pad_drv_o}); end
      set_cfg(1, 0, 1, 2'b01, 0, 0, 4'd1);
      tick();
      checks++; if ({pad_drv_o, pad_puen_o, busy_o} !== 4'b1001) begin errors++; $display("FAIL bp_hold got %b exp 1001", {pad_drv_o, pad_puen_o, busy_o}); end
      tick();
      checks++; if ({pad_drv_o, cfg_ready_o, pad_oen_o} !== 4'b1010) begin errors++; $display("FAIL bp_ready got %b exp 1010", {pad_drv_o, cfg_ready_o, pad_oen_o}); end
      tick();
      cfg_valid_i = 1'b0;
      checks++; if ({pad_drv_o, pad_puen_o, busy_o, pad_oen_o} !== 5'b01111) begin errors++; $display("FAIL bp_apply got %b exp 01111", {pad_drv_o, pad_puen_o, busy_o, pad_oen_o}); end
      tick();
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL bp_turn got %b exp 1", busy_o); end
      tick();
      checks++; if ({busy_o, pad_oen_o} !== 2'b01) begin errors++; $display("FAIL bp_done got %b exp 01", {busy_o, pad_oen_o}); end
      tick();
      checks++; if ({busy_o, cfg_ready_o, pad_drv_o} !== 4'b0101) begin errors++; $display("FAIL bp_once got %b exp 0101", {busy_o, cfg_ready_o, pad_drv_o}); end
   endtask

   // pad_i_o follows out_data_i by one cycle in every state, including TURN.
   task automatic test_data_path();
      logic exp;
      for (int i = 0; i < 24; i++) begin
         out_data_i = 1'($urandom_range(0, 1));
         exp_q.push_back(out_data_i);
         if (i == 5) set_cfg(1, 1, 0, 2'b00, 0, 0, 4'd1);
         tick();
         if (i == 5) cfg_valid_i = 1'b0;
         exp = exp_q.pop_front();
         checks++; if (pad_i_o !== exp) begin errors++; $display("FAIL data%0d got %b exp %b", i, pad_i_o, exp); end
      end
      checks++; if (pad_oen_o !== 1'b0) begin errors++; $display("FAIL data_oen got %b exp 0", pad_oen_o); end
   endtask

   task automatic test_reset_mid_turn();
      out_data_i = 1'b1;
      set_cfg(1, 0, 1, 2'b11, 1, 1, 4'd2);
      tick();
      cfg_valid_i = 1'b0;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_turn got %b exp 1", busy_o); end
      #2 rst_ni = 1'b0;
      #1;
      checks++; if ({cfg_ready_o, busy_o, pad_oen_o} !== 3'b101) begin errors++; $display("FAIL mid_ctrl got %b exp 101", {cfg_ready_o, busy_o, pad_oen_o}); end
      checks++; if ({pad_puen_o, pad_drv_o, pad_slw_o, pad_smt_o, pad_i_o} !== 6'b0) begin errors++; $display("FAIL mid_padcfg got %b exp 000000", {pad_puen_o, pad_drv_o, pad_slw_o, pad_smt_o, pad_i_o}); end
      tick();
      rst_ni = 1'b1;
      out_data_i = 1'b0;
      tick();
      checks++; if ({cfg_ready_o, busy_o, pad_oen_o, pad_drv_o} !== 5'b10100) begin errors++; $display("FAIL mid_after got %b exp 10100", {cfg_ready_o, busy_o, pad_oen_o, pad_drv_o}); end
      // Direction is input after reset, so an input-mode request needs no turnaround.
      set_cfg(1, 0, 0, 2'b10, 0, 0, 4'd1);
      tick();
      cfg_valid_i = 1'b0;
      checks++; if ({busy_o, pad_drv_o, pad_oen_o} !== 4'b0101) begin errors++; $display("FAIL post_rst_dir got %b exp 0101", {busy_o, pad_drv_o, pad_oen_o}); end
   endtask

   initial begin
      test_reset();
      test_in_to_out();
      test_debounce();
      test_same_dir();
      test_out_to_in();
      test_backpressure();
      test_data_path();
      test_reset_mid_turn();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pad_alsaqr_ctrl.md
PAD_ALSAQR_CTRL -- requirements
Module: pad_alsaqr_ctrl

Interface
REQ-001 SHALL have parameter TURN_CYC, default 2: output-to-input and input-to-output turnaround cycles, legal range 1..15.
REQ-002 SHALL have parameter DEB_W, default 4: debounce counter and threshold width.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports cfg_valid_i (input, 1) and cfg_ready_o (output, 1): configuration handshake.
REQ-006 SHALL have the following configuration payload inputs:
- cfg_dir_i, 1: 1 = output mode.
- cfg_puen_i, 1: 1 = pull-up, 0 = pull-down.
- cfg_drv_i, 2: drive strength.
- cfg_slw_i, 1: slew control.
- cfg_smt_i, 1: Schmitt-trigger enable.
- cfg_deb_i, DEB_W: debounce threshold.
REQ-007 SHALL have port out_data_i, input, 1: core data to drive onto the pad.
REQ-008 SHALL have ports in_data_o (output, 1) and in_edge_o (output, 1): debounced pad input, and a one-cycle pulse on each in_data_o change.
REQ-009 SHALL have port busy_o, output, 1: high while a turnaround is in progress.
REQ-010 SHALL have the following pad-side ports:
- pad_i_o, output, 1: pad DATA.
- pad_oen_o, output, 1: 1 = tristate and receiver on.
- pad_puen_o, output, 1.
- pad_drv_o, output, 2.
- pad_slw_o, output, 1.
- pad_smt_o, output, 1.
- pad_o_i, input, 1: pad Y.

Function
REQ-011 SHALL accept a configuration on a rising edge where cfg_valid_i=1 and cfg_ready_o=1.
REQ-012 SHALL drive cfg_ready_o=1 in state IDLE and 0 in state TURN.
REQ-013 SHALL use FSM states IDLE and TURN only.
REQ-014 SHALL, when cfg_dir_i equals the current direction, register puen/drv/slw/smt/deb on the accept edge, visible on the next cycle, and remain in IDLE.
REQ-015 SHALL, on input-to-output accept:
- register puen/drv/slw/smt/deb on the accept edge;
- hold pad_oen_o=1 for TURN_CYC cycles in TURN;
- drive pad_oen_o=0 on the edge that returns the FSM to IDLE.
REQ-016 SHALL, on output-to-input accept:
- drive pad_oen_o=1 and register the new config on the accept edge;
- stay in TURN for TURN_CYC cycles, then return to IDLE.
REQ-017 SHALL hold busy_o=1 exactly while in TURN.
REQ-018 SHALL count turnaround cycles with a counter loaded with TURN_CYC-1 on accept, decremented each cycle, and leave TURN on the edge where it equals 0.
REQ-019 SHALL ignore cfg_valid_i while cfg_ready_o=0; the requester holds its payload stable until accepted.
REQ-020 SHALL register pad_i_o from out_data_i every cycle (1-cycle latency) in every state; the pad masks it via pad_oen_o.
REQ-021 SHALL pass pad_o_i through a 2-flop synchronizer.
REQ-022 SHALL debounce the synchronizer output as follows:
- the counter increments (saturating at its maximum) each cycle the synchronized value differs from in_data_o;
- the counter clears each cycle they are equal;
- in_data_o takes the synchronized value on the edge of the N-th consecutive mismatch cycle, N = max(1, deb), and the counter clears on that edge.
REQ-023 SHALL assert in_edge_o for exactly the one cycle following each in_data_o update.
REQ-024 SHALL freeze the debounce counter and in_data_o while in TURN, and resume counting from 0 on return to IDLE.
REQ-025 SHALL keep debouncing in output mode, providing pad readback.
REQ-026 SHALL apply a new deb threshold from the accept edge onward, without clearing a mismatch count already in progress.

Reset
REQ-027 SHALL, while rst_ni=0, asynchronously force:
- FSM to IDLE;
- cfg_ready_o=1, busy_o=0;
- pad_oen_o=1, pad_puen_o=0, pad_drv_o=2'b00, pad_slw_o=0, pad_smt_o=0, pad_i_o=0;
- in_data_o=0, in_edge_o=0;
- synchronizer flops, debounce counter, turnaround counter and deb threshold to 0.
REQ-028 SHALL abandon any turnaround on reset assertion mid-TURN; no partial configuration survives.
REQ-029 SHALL leave the direction as input after reset.

Verification
REQ-030 SHALL verify reset: assert rst_ni=0 mid-cycle -> all outputs take REQ-027 values immediately, without a clock edge.
REQ-031 SHALL verify input-to-output: TURN_CYC=2; accept dir=1, drv=2'b11 at edge t -> pad_drv_o=3 after t, pad_oen_o=1 through edge t+1, pad_oen_o=0 after t+2; busy_o=1 for 2 cycles; cfg_ready_o=0 for 2 cycles.
REQ-032 SHALL verify output-to-input: from output mode, accept dir=0 at edge t -> pad_oen_o=1 after t; in_data_o frozen for 2 cycles despite pad_o_i toggling; IDLE after t+2.
REQ-033 SHALL verify debounce: deb=3; pad_o_i 0->1 held stable from edge e -> in_data_o=1 after edge e+5, with in_edge_o high that cycle only. A 2-cycle glitch (1 then 0) -> no change.
REQ-034 SHALL verify a same-direction reconfig: accept smt=1, dir unchanged -> pad_smt_o=1 next cycle, busy_o stays 0, and a back-to-back second accept on the next edge succeeds.
REQ-035 SHALL verify back-pressure: cfg_valid_i held high during TURN with a different payload -> not accepted until cfg_ready_o=1, then applied exactly once.
